// File: rtl/reg_dump_if.sv
// Handshake and bus bundle between the register-dump engine and its
// register file / consumer side.
interface reg_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_stale;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, abort, first_addr, last_addr,
    input  rd_data, wr_en, wr_addr, out_ready,
    output rd_addr, out_valid, out_addr, out_data,
    output out_stale, busy, done, err
  );

  modport slave (
    output start, abort, first_addr, last_addr,
    output rd_data, wr_en, wr_addr, out_ready,
    input  rd_addr, out_valid, out_addr, out_data,
    input  out_stale, busy, done, err
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks a register-file address range and streams {addr, data} words,
// flagging any held word whose register is overwritten before acceptance.
module reg_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic        clk,
  input logic        rst,
  reg_dump_if.master bus
);
  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_stale;
  logic              busy;
  logic              done;
  logic              err;
  logic              hit_cur;
  logic              hit_out;

  assign hit_cur = bus.wr_en && (bus.wr_addr == cur);
  assign hit_out = bus.wr_en && (bus.wr_addr == out_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      last_q    <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_stale <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.first_addr <= bus.last_addr) begin
              cur    <= bus.first_addr;
              last_q <= bus.last_addr;
              busy   <= 1'b1;
              state  <= READ;
            end else begin
              err <= 1'b1;
            end
          end
        end
        READ: begin
          if (bus.abort) begin
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_stale <= 1'b0;
            state     <= IDLE;
          end else begin
            // a same-edge write still lands after this capture
            out_addr  <= cur;
            out_data  <= bus.rd_data;
            out_valid <= 1'b1;
            out_stale <= hit_cur;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.abort) begin
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_stale <= 1'b0;
            state     <= IDLE;
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
            out_stale <= 1'b0;
            if (cur == last_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cur   <= cur + 1'b1;
              state <= READ;
            end
          end else if (hit_out) begin
            out_stale <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_addr   = busy ? cur : '0;
  assign bus.out_valid = out_valid;
  assign bus.out_addr  = out_addr;
  assign bus.out_data  = out_data;
  assign bus.out_stale = out_stale;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;
endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: range table, hand sequences for hold/stale/
// abort/reset, then random traffic against a word-queue reference.
module tb_reg_dump_reader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_dump_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] rf [32];
  logic [31:0] wr_data;
  int total = 0;
  int bad   = 0;

  assign bus.rd_data = rf[bus.rd_addr];
  always @(posedge clk) if (bus.wr_en) rf[bus.wr_addr] <= wr_data;

  typedef struct {
    int   first;
    int   last;
    logic exp_err;
    int   exp_n;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, x);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'(a);
    wr_data     = d;
    tick;
    bus.wr_en   = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 0);
    chk({tag, "_stale"}, 64'(bus.out_stale), 0);
    chk({tag, "_busy"}, 64'(bus.busy), 0);
    chk({tag, "_done"}, 64'(bus.done), 0);
    chk({tag, "_err"}, 64'(bus.err), 0);
    chk({tag, "_rdaddr"}, 64'(bus.rd_addr), 0);
    chk({tag, "_oaddr"}, 64'(bus.out_addr), 0);
    chk({tag, "_odata"}, 64'(bus.out_data), 0);
  endtask

  // Full dump with out_ready held high; word k appears at cycle 2k+2.
  task automatic run_range(input int f, input int l,
                           input logic e_err, input int n);
    int k;
    logic ev;
    bus.first_addr = 5'(f);
    bus.last_addr  = 5'(l);
    bus.out_ready  = 1'b1;
    bus.start      = 1'b1;
    tick;
    bus.start      = 1'b0;
    bus.first_addr = bus.first_addr ^ 5'h15;
    bus.last_addr  = bus.last_addr ^ 5'h0a;
    if (e_err) begin
      chk("rng_err", 64'(bus.err), 1);
      chk("rng_err_busy", 64'(bus.busy), 0);
      chk("rng_err_valid", 64'(bus.out_valid), 0);
      tick;
      chk("rng_err_pulse", 64'(bus.err), 0);
      chk("rng_err_valid2", 64'(bus.out_valid), 0);
    end else begin
      for (int c = 1; c <= 2 * n + 2; c++) begin
        if (c > 1) tick;
        k  = (c - 1) / 2;
        ev = (c % 2 == 0) && (c <= 2 * n);
        chk("rng_valid", 64'(bus.out_valid), 64'(ev));
        chk("rng_busy", 64'(bus.busy), 64'(c <= 2 * n));
        chk("rng_done", 64'(bus.done), 64'(c == 2 * n + 1));
        chk("rng_err0", 64'(bus.err), 0);
        chk("rng_rdaddr", 64'(bus.rd_addr),
            (c <= 2 * n) ? 64'(f + k) : 0);
        if (ev) begin
          chk("rng_addr", 64'(bus.out_addr), 64'(f + k));
          chk("rng_data", 64'(bus.out_data), 64'(rf[5'(f + k)]));
          chk("rng_stale", 64'(bus.out_stale), 0);
        end
      end
    end
  endtask

  // Random traffic; reference is a word pointer with capture snapshots.
  task automatic random_run(input int cycles);
    logic        act = 1'b0;
    int          cap_c = 0;
    int          done_c = -5;
    int          err_c = -5;
    int          idle_ok = 0;
    int          a_cur = 0;
    int          last_r = 0;
    logic [31:0] snap = '0;
    logic        st = 1'b0;
    int          f;
    int          l;
    int          t;
    for (int e = 0; e < cycles; e++) begin
      tick;
      chk("rv_valid", 64'(bus.out_valid), 64'(act && e >= cap_c));
      chk("rv_done", 64'(bus.done), 64'(e == done_c));
      chk("rv_err", 64'(bus.err), 64'(e == err_c));
      if (act && e == cap_c - 1) snap = rf[5'(a_cur)];
      bus.start      = 1'b0;
      bus.first_addr = 5'($urandom_range(0, 31));
      bus.last_addr  = 5'($urandom_range(0, 31));
      if (act && $urandom_range(0, 7) == 0) bus.start = 1'b1;
      bus.out_ready = 1'($urandom_range(0, 1));
      if (act && e >= cap_c && bus.out_ready) begin
        chk("rv_addr", 64'(bus.out_addr), 64'(a_cur));
        chk("rv_data", 64'(bus.out_data), 64'(snap));
        chk("rv_stale", 64'(bus.out_stale), 64'(st));
        st = 1'b0;
        if (a_cur == last_r) begin
          act     = 1'b0;
          done_c  = e + 1;
          idle_ok = e + 2;
        end else begin
          a_cur++;
          cap_c = e + 2;
        end
      end
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_addr = $urandom_range(0, 1) ? 5'(a_cur)
                                         : 5'($urandom_range(0, 31));
      wr_data     = $urandom;
      if (act && bus.wr_en && int'(bus.wr_addr) == a_cur && e + 1 >= cap_c)
        st = 1'b1;
      if (!act && e >= idle_ok && $urandom_range(0, 3) == 0) begin
        f = $urandom_range(0, 31);
        l = $urandom_range(0, 31);
        if ($urandom_range(0, 7) != 0 && f > l) begin
          t = f;
          f = l;
          l = t;
        end
        bus.first_addr = 5'(f);
        bus.last_addr  = 5'(l);
        bus.start      = 1'b1;
        if (f <= l) begin
          act    = 1'b1;
          a_cur  = f;
          last_r = l;
          cap_c  = e + 2;
          st     = 1'b0;
        end else begin
          err_c   = e + 1;
          idle_ok = e + 1;
        end
      end
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{first: 1,  last: 3,  exp_err: 1'b0, exp_n: 3};
    vecs[1] = '{first: 4,  last: 2,  exp_err: 1'b1, exp_n: 0};
    vecs[2] = '{first: 31, last: 31, exp_err: 1'b0, exp_n: 1};
    vecs[3] = '{first: 0,  last: 0,  exp_err: 1'b0, exp_n: 1};
    vecs[4] = '{first: 28, last: 31, exp_err: 1'b0, exp_n: 4};
    vecs[5] = '{first: 10, last: 9,  exp_err: 1'b1, exp_n: 0};
    vecs[6] = '{first: 0,  last: 31, exp_err: 1'b0, exp_n: 32};

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.first_addr = '0;
    bus.last_addr  = '0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.out_ready  = 1'b0;
    wr_data        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 32; i++) wr(i, 32'(i) * 32'h11);

    foreach (vecs[i])
      run_range(vecs[i].first, vecs[i].last, vecs[i].exp_err, vecs[i].exp_n);

    // word 2 held five cycles; start kept high with a new range is ignored
    bus.first_addr = 5'd1;
    bus.last_addr  = 5'd3;
    bus.start      = 1'b1;
    bus.out_ready  = 1'b1;
    tick;
    bus.first_addr = 5'd0;
    bus.last_addr  = 5'd0;
    chk("hold_read", 64'(bus.out_valid), 0);
    tick;
    chk("hold_w1_addr", 64'(bus.out_addr), 1);
    chk("hold_w1_data", 64'(bus.out_data), 32'h11);
    tick;
    chk("hold_gap", 64'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("hold_w2_valid", 64'(bus.out_valid), 1);
      chk("hold_w2_addr", 64'(bus.out_addr), 2);
      chk("hold_w2_data", 64'(bus.out_data), 32'h22);
    end
    bus.out_ready = 1'b1;
    tick;
    chk("hold_gap2", 64'(bus.out_valid), 0);
    tick;
    chk("hold_w3_addr", 64'(bus.out_addr), 3);
    chk("hold_w3_data", 64'(bus.out_data), 32'h33);
    bus.start = 1'b0;
    tick;
    chk("hold_done", 64'(bus.done), 1);
    tick;
    chk("hold_done_off", 64'(bus.done), 0);
    chk("hold_busy_off", 64'(bus.busy), 0);

    // stale flag, then abort racing an accept
    bus.first_addr = 5'd1;
    bus.last_addr  = 5'd3;
    bus.start      = 1'b1;
    bus.out_ready  = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    bus.out_ready = 1'b0;
    tick;
    chk("st_addr", 64'(bus.out_addr), 2);
    chk("st_init", 64'(bus.out_stale), 0);
    wr(5, 32'h55);
    chk("st_other", 64'(bus.out_stale), 0);
    wr(2, 32'hAA);
    chk("st_hit", 64'(bus.out_stale), 1);
    chk("st_data", 64'(bus.out_data), 32'h22);
    tick;
    chk("st_sticky", 64'(bus.out_stale), 1);
    bus.abort     = 1'b1;
    bus.out_ready = 1'b1;
    tick;
    bus.abort = 1'b0;
    chk("ab_valid", 64'(bus.out_valid), 0);
    chk("ab_stale", 64'(bus.out_stale), 0);
    chk("ab_busy", 64'(bus.busy), 0);
    chk("ab_done", 64'(bus.done), 0);
    tick;
    chk("ab_done2", 64'(bus.done), 0);
    chk("ab_valid2", 64'(bus.out_valid), 0);
    run_range(1, 3, 1'b0, 3);

    // asynchronous reset in the middle of a READ cycle
    bus.first_addr = 5'd0;
    bus.last_addr  = 5'd4;
    bus.start      = 1'b1;
    bus.out_ready  = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    chk("rst_pre_busy", 64'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk_zero("arst");
    tick;
    chk_zero("arst_hold");
    rst = 1'b0;
    tick;
    run_range(0, 4, 1'b0, 5);

    random_run(1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
